// File: rtl/shared_pkg.sv
// Shared APB types and default geometry for the master and the slave-side interconnect.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shared_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int NO_SLAVES      = 4;
    localparam int SEL_LSB        = 12;
    localparam int TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Slave decode: the address field at SEL_LSB selects one slave; out-of-range indices miss.
// Latency: combinational.
// Backpressure: none.
module apb_addr_decoder #(
    parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH,
    parameter int NO_SLAVES  = shared_pkg::NO_SLAVES,
    parameter int SEL_LSB    = shared_pkg::SEL_LSB
) (
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  hit,
    output logic [NO_SLAVES-1:0]  sel
);

    localparam int IDX_W = (NO_SLAVES > 1) ? $clog2(NO_SLAVES) : 1;

    logic [IDX_W-1:0] idx;
    logic             unused_addr;

    assign unused_addr = ^req_addr;

    generate
        if (NO_SLAVES == 1) begin : g_single
            assign idx = '0;
        end else begin : g_multi
            assign idx = req_addr[SEL_LSB +: IDX_W];
        end
    endgenerate

    always_comb begin
        hit = ({1'b0, idx} < (IDX_W+1)'(NO_SLAVES));
        sel = '0;
        for (int i = 0; i < NO_SLAVES; i++) begin
            sel[i] = hit && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/apb_multi_slave_master.sv
// APB4 master: one request at a time fanned out to NO_SLAVES slaves; optional ACCESS timeout via APB_TIMEOUT_EN.
// Latency: 3 cycles accept-to-rsp_valid plus one per wait state; decode miss responds next cycle.
// Backpressure: req_ready only in IDLE; PREADY low stretches ACCESS.
module apb_multi_slave_master #(
    parameter int DATA_WIDTH     = shared_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = shared_pkg::ADDR_WIDTH,
    parameter int NO_SLAVES      = shared_pkg::NO_SLAVES,
    parameter int SEL_LSB        = shared_pkg::SEL_LSB,
    parameter int TIMEOUT_CYCLES = shared_pkg::TIMEOUT_CYCLES
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    input  logic [DATA_WIDTH/8-1:0]         req_strb,
    output logic                            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [NO_SLAVES-1:0]            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH/8-1:0]         PSTRB,
    input  logic [NO_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NO_SLAVES-1:0]            PREADY,
    input  logic [NO_SLAVES-1:0]            PSLVERR
);

    import shared_pkg::*;

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [NO_SLAVES-1:0]    psel_d;
    logic                    penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d, rsp_rdata_d, sel_rdata;
    logic [STRB_W-1:0]       pstrb_d;
    logic                    dec_hit, sel_ready, sel_err, timeout;
    logic [NO_SLAVES-1:0]    dec_sel;

`ifdef APB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    // Terminal count is judged on the last permitted wait cycle so PREADY in that cycle still wins.
    assign timeout = (cnt_q == CNT_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NO_SLAVES  (NO_SLAVES),
        .SEL_LSB    (SEL_LSB)
    ) u_dec (
        .req_addr (req_addr),
        .hit      (dec_hit),
        .sel      (dec_sel)
    );

    assign req_ready = (state_q == IDLE) && !PRESET;

    // Mask every slave return with PSEL so unselected slaves (even X) never reach the response.
    always_comb begin
        sel_ready = |(PREADY & PSEL);
        sel_err   = |(PSLVERR & PSEL);
        sel_rdata = '0;
        for (int i = 0; i < NO_SLAVES; i++) begin
            sel_rdata = sel_rdata | (PRDATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{PSEL[i]}});
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        pstrb_d     = PSTRB;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (dec_hit) begin
                        psel_d   = dec_sel;
                        pwrite_d = req_write;
                        paddr_d  = req_addr;
                        pwdata_d = req_wdata;
                        pstrb_d  = req_write ? req_strb : '0;
                        state_d  = SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = PWRITE ? '0 : sel_rdata;
                    rsp_err_d   = sel_err;
                end else begin
`ifdef APB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                    if (timeout) begin
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            PSTRB     <= pstrb_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule
